l0_buffer_status_ctrl: RTL and testbench

L0_BUFFER_STATUS_CTRL -- requirements
Module: l0_buffer_status_ctrl

---
 rtl/l0_buffer_status_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_l0_buffer_status_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/l0_buffer_status_ctrl.sv
// L0 buffer status controller: per-channel load tracking, tile step counting and run sequencing.
// Optional sticky protocol-error flag enabled by defining L0_STATUS_ERR_CHECK_EN.
module l0_buffer_status_ctrl #(
  parameter int unsigned NUM_CH        = 3,
  parameter int unsigned CNT_W         = 11,
  parameter int unsigned LOAD_OVERHEAD = 100,
  parameter int unsigned L0_STEPS      = 19,
  parameter int unsigned STEP_W        = 5,
  parameter int unsigned TILE_W        = 6,
  parameter int unsigned NUM_TILES     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       mem_valid,
  input  logic [NUM_CH*CNT_W-1:0] ch_depth,
  output logic [2*NUM_CH-1:0]     status,
  output logic                    all_ready,
  output logic [STEP_W-1:0]       step_cnt,
  output logic [TILE_W-1:0]       tile_idx,
  output logic                    tile_end,
  output logic                    done,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StLoading = 2'b01,
    StReady   = 2'b10,
    StDone    = 2'b11
  } ch_state_e;

  localparam logic [STEP_W-1:0] LastStep = STEP_W'(L0_STEPS - 1);
  localparam logic [TILE_W-1:0] LastTile = TILE_W'(NUM_TILES - 1);
  localparam logic [CNT_W:0]    Overhead = (CNT_W + 1)'(LOAD_OVERHEAD);

  ch_state_e               state_q [NUM_CH];
  ch_state_e               state_d [NUM_CH];
  logic [CNT_W-1:0]        cnt_q   [NUM_CH];
  logic [CNT_W-1:0]        cnt_d   [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] depth_q, depth_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [TILE_W-1:0]       tile_q, tile_d;
  logic                    done_q, done_d;
  logic [NUM_CH-1:0]       load_hit;
  logic                    last_tile;

  // Compare cnt+1 against overhead+depth so the sum never wraps at CNT_W bits.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      load_hit[i] = (({1'b0, cnt_q[i]} + (CNT_W + 1)'(1)) ==
                     (Overhead + {1'b0, depth_q[i*CNT_W +: CNT_W]}));
    end
  end

  always_comb begin
    all_ready = 1'b1;
    busy      = 1'b0;
    status    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      status[2*i +: 2] = state_q[i];
      if (state_q[i] != StReady) begin
        all_ready = 1'b0;
      end
      if (state_q[i] == StLoading || state_q[i] == StReady) begin
        busy = 1'b1;
      end
    end
  end

  assign last_tile = (tile_q == LastTile);
  assign tile_end  = all_ready && (step_q == LastStep);
  assign step_cnt  = step_q;
  assign tile_idx  = tile_q;
  assign done      = done_q;

  always_comb begin
    step_d  = step_q;
    tile_d  = tile_q;
    depth_d = depth_q;
    done_d  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end

    if (start) begin
      depth_d = ch_depth;
      step_d  = '0;
      tile_d  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_d[i] = StLoading;
        cnt_d[i]   = '0;
      end
    end else if (tile_end) begin
      step_d = '0;
      if (last_tile) begin
        done_d = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          state_d[i] = StDone;
        end
      end else begin
        tile_d = tile_q + TILE_W'(1);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          state_d[i] = StLoading;
          cnt_d[i]   = '0;
        end
      end
    end else begin
      if (all_ready) begin
        step_d = step_q + STEP_W'(1);
      end
      // Only loading channels react to mem_valid; everything else holds.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (state_q[i] == StLoading && mem_valid[i]) begin
          if (load_hit[i]) begin
            state_d[i] = StReady;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      depth_q <= '0;
      step_q  <= '0;
      tile_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      depth_q <= depth_d;
      step_q  <= step_d;
      tile_q  <= tile_d;
      done_q  <= done_d;
    end
  end

`ifdef L0_STATUS_ERR_CHECK_EN
  logic              err_q, err_d;
  logic [NUM_CH-1:0] stray_valid;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      stray_valid[i] = mem_valid[i] && (state_q[i] != StLoading);
    end
  end

  // A start clears the flag unless it interrupts a live run.
  always_comb begin
    err_d = err_q;
    if (start) begin
      err_d = busy;
    end else if (|stray_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_l0_buffer_status_ctrl.sv
// Self-checking bench for l0_buffer_status_ctrl: table of per-cycle vectors fed through a
// scoreboard queue, covering load timing, stalls, full run, restart, reset and error flag.
module tb_l0_buffer_status_ctrl;

  localparam int unsigned NUM_CH        = 3;
  localparam int unsigned CNT_W         = 11;
  localparam int unsigned LOAD_OVERHEAD = 2;
  localparam int unsigned L0_STEPS      = 4;
  localparam int unsigned STEP_W        = 5;
  localparam int unsigned TILE_W        = 6;
  localparam int unsigned NUM_TILES     = 2;

`ifdef L0_STATUS_ERR_CHECK_EN
  localparam logic ErrOn = 1'b1;
`else
  localparam logic ErrOn = 1'b0;
`endif

  localparam logic [5:0] SIdle = 6'b000000;
  localparam logic [5:0] SLoad = 6'b010101;
  localparam logic [5:0] SRdy  = 6'b101010;
  localparam logic [5:0] SDone = 6'b111111;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [NUM_CH-1:0]       mem_valid;
  logic [NUM_CH*CNT_W-1:0] ch_depth;
  logic [2*NUM_CH-1:0]     status;
  logic                    all_ready;
  logic [STEP_W-1:0]       step_cnt;
  logic [TILE_W-1:0]       tile_idx;
  logic                    tile_end;
  logic                    done;
  logic                    busy;
  logic                    err;

  l0_buffer_status_ctrl #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .LOAD_OVERHEAD(LOAD_OVERHEAD),
    .L0_STEPS     (L0_STEPS),
    .STEP_W       (STEP_W),
    .TILE_W       (TILE_W),
    .NUM_TILES    (NUM_TILES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_valid(mem_valid),
    .ch_depth (ch_depth),
    .status   (status),
    .all_ready(all_ready),
    .step_cnt (step_cnt),
    .tile_idx (tile_idx),
    .tile_end (tile_end),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] mv;
    logic       chk;
    logic [5:0] st;
    logic       ar;
    logic [4:0] step;
    logic [5:0] tile;
    logic       te;
    logic       dn;
    logic       bsy;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   row_id = 0;

  task automatic add(input logic r, input logic s, input logic [2:0] mv, input logic c,
                     input logic [5:0] st, input logic ar, input int step, input int tile,
                     input logic te, input logic dn, input logic bsy, input logic e);
    vec_t v;
    v.rst = r; v.start = s; v.mv = mv; v.chk = c; v.st = st; v.ar = ar;
    v.step = 5'(step); v.tile = 6'(tile); v.te = te; v.dn = dn; v.bsy = bsy; v.err = e;
    tbl.push_back(v);
  endtask

  // Reset cycle followed by one checked idle cycle.
  task automatic add_reset();
    add(1'b1, 1'b0, 3'b000, 1'b0, SIdle, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'bx);
    add(1'b0, 1'b0, 3'b000, 1'b1, SIdle, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, expv);
    end
  endtask

  task automatic run_table();
    vec_t e;
    foreach (tbl[i]) begin
      @(negedge clk);
      rst       = tbl[i].rst;
      start     = tbl[i].start;
      mem_valid = tbl[i].mv;
      if (tbl[i].chk) exp_q.push_back(tbl[i]);
      #2;
      if (tbl[i].chk) begin
        e = exp_q.pop_front();
        cmp("status",    row_id, 32'(status),    32'(e.st));
        cmp("all_ready", row_id, 32'(all_ready), 32'(e.ar));
        cmp("step_cnt",  row_id, 32'(step_cnt),  32'(e.step));
        cmp("tile_idx",  row_id, 32'(tile_idx),  32'(e.tile));
        cmp("tile_end",  row_id, 32'(tile_end),  32'(e.te));
        cmp("done",      row_id, 32'(done),      32'(e.dn));
        cmp("busy",      row_id, 32'(busy),      32'(e.bsy));
        if (e.err !== 1'bx) cmp("err", row_id, 32'(err), 32'(e.err));
      end
      row_id++;
    end
    tbl.delete();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mem_valid = '0;
    ch_depth  = {11'd4, 11'd3, 11'd2};

    // Nominal load timing and a full two-tile run with valid always high.
    add_reset();
    add(0, 1, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) add(0, 0, 3'b111, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'bx);
    add(0, 0, 3'b111, 1, 6'b010110, 0, 0, 0, 0, 0, 1, 1'bx);
    add(0, 0, 3'b111, 1, 6'b011010, 0, 0, 0, 0, 0, 1, 1'bx);
    for (int k = 0; k < 4; k++)
      add(0, 0, 3'b111, 1, SRdy, 1, k, 0, (k == 3), 0, 1, 1'bx);
    for (int k = 0; k < 4; k++) add(0, 0, 3'b111, 1, SLoad, 0, 0, 1, 0, 0, 1, 1'bx);
    add(0, 0, 3'b111, 1, 6'b010110, 0, 0, 1, 0, 0, 1, 1'bx);
    add(0, 0, 3'b111, 1, 6'b011010, 0, 0, 1, 0, 0, 1, 1'bx);
    for (int k = 0; k < 4; k++)
      add(0, 0, 3'b111, 1, SRdy, 1, k, 1, (k == 3), 0, 1, 1'bx);
    add(0, 0, 3'b111, 1, SDone, 0, 0, 1, 0, 1, 0, ErrOn);
    add(0, 0, 3'b111, 1, SDone, 0, 0, 1, 0, 0, 0, ErrOn);
    add(0, 0, 3'b000, 1, SDone, 0, 0, 1, 0, 0, 0, ErrOn);
    run_table();

    // Channel 1 stalled for three cycles.
    add_reset();
    add(0, 1, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    add(0, 0, 3'b111, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'b0);
    for (int k = 0; k < 3; k++) add(0, 0, 3'b101, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'b0);
    add(0, 0, 3'b111, 1, 6'b010110, 0, 0, 0, 0, 0, 1, 1'b0);
    add(0, 0, 3'b111, 1, 6'b010110, 0, 0, 0, 0, 0, 1, 1'bx);
    add(0, 0, 3'b111, 1, 6'b100110, 0, 0, 0, 0, 0, 1, 1'bx);
    add(0, 0, 3'b111, 1, 6'b100110, 0, 0, 0, 0, 0, 1, 1'bx);
    add(0, 0, 3'b000, 1, SRdy, 1, 0, 0, 0, 0, 1, 1'bx);
    run_table();

    // Restart at step 2 of tile 1.
    add_reset();
    add(0, 1, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 18; k++) add(0, 0, 3'b111, 0, SIdle, 0, 0, 0, 0, 0, 0, 1'bx);
    add(0, 1, 3'b111, 1, SRdy, 1, 2, 1, 0, 0, 1, 1'bx);
    add(0, 0, 3'b000, 1, SLoad, 0, 0, 0, 0, 0, 1, ErrOn);
    add(0, 0, 3'b000, 1, SLoad, 0, 0, 0, 0, 0, 1, ErrOn);
    run_table();

    // Reset mid-load, reset beating start, then a clean reload.
    add_reset();
    add(0, 1, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    add(0, 0, 3'b111, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'b0);
    add(0, 0, 3'b111, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'b0);
    add(1, 0, 3'b111, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'b0);
    add(0, 0, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    add(1, 1, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    add(0, 0, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    add(0, 1, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) add(0, 0, 3'b111, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'b0);
    add(0, 0, 3'b000, 1, 6'b010110, 0, 0, 0, 0, 0, 1, 1'b0);
    run_table();

    // Stray mem_valid on a READY channel.
    add_reset();
    add(0, 1, 3'b000, 1, SIdle, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) add(0, 0, 3'b111, 1, SLoad, 0, 0, 0, 0, 0, 1, 1'b0);
    add(0, 0, 3'b001, 1, 6'b010110, 0, 0, 0, 0, 0, 1, 1'b0);
    add(0, 0, 3'b000, 1, 6'b010110, 0, 0, 0, 0, 0, 1, ErrOn);
    add(0, 0, 3'b000, 1, 6'b010110, 0, 0, 0, 0, 0, 1, ErrOn);
    add(0, 1, 3'b000, 1, 6'b010110, 0, 0, 0, 0, 0, 1, ErrOn);
    add(0, 0, 3'b000, 1, SLoad, 0, 0, 0, 0, 0, 1, ErrOn);
    run_table();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
